cdm_seq_approx_mul: RTL
=======================

Name: cdm_seq_approx_mul

Overview:
- Parametrised, iterative carry-disregard approximate multiplier, unsigned WIDTH x WIDTH -> 2*WIDTH.
- Processes B one 4-bit digit per cycle. Each digit partial product is formed with its low APPROX_COLS columns carry-disregarded. Digit products are then accumulated exactly.
- Generalises the fixed 8x8 two-digit combinational multiplier with a width parameter, a per-transaction exact/approximate mode and valid/ready handshakes.
- Sits between operand producers and accumulate/datapath consumers in the approximate-arithmetic library.

Parameters:
- WIDTH, 8, operand width in bits; must be a multiple of 4 and >= 4.
- APPROX_COLS, 6, number of low columns of each digit product built without carries; valid range 0..WIDTH+3; 0 gives an exact result.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; synchronous, active-high.
- in_valid, input, 1, operands present.
- in_ready, output, 1, block can accept operands.
- in_a, input, WIDTH, multiplicand A.
- in_b, input, WIDTH, multiplier B.
- in_approx, input, 1, 1 = approximate digit products, 0 = exact.
- out_valid, output, 1, result present.
- out_ready, input, 1, consumer accepts result.
- out_r, output, 2*WIDTH, product.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; in_ready=1, out_valid=0, out_r=0; accumulator and digit counter cleared.
- rst has priority over every other event. Reset mid-operation discards the transaction; no result is ever emitted for it.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, latch A, B and mode; acc=0; cnt=0; go to BUSY.
  - BUSY: in_ready=0. Each cycle, d = B[4*cnt+3:4*cnt] and acc += P(A,d) << 4*cnt. After cnt = WIDTH/4-1, go to DONE; otherwise cnt++.
  - DONE: out_valid=1, out_r=acc, held stable until out_ready. On out_valid&out_ready, go to IDLE.
- Digit product P(A,d), with row i = A<<i if d[i] else 0 (i = 0..3):
  - Exact mode: P = A*d.
  - Approximate mode, column j < APPROX_COLS: bit j = OR of all row bits in column j. No carry is generated or passed upward.
  - Approximate mode, columns >= APPROX_COLS: exact sum of the rows with their low APPROX_COLS bits cleared.
- Accumulation over digits is exact. The approximate P is never greater than the exact P, so acc never exceeds 2*WIDTH bits.
- Latency: accept edge, then WIDTH/4 BUSY cycles, then out_valid. Example: WIDTH=8 gives out_valid 3 cycles after the accept edge.
- Throughput: one transaction per WIDTH/4+2 cycles when out_ready is held at 1.
- in_ready is low in BUSY and DONE. No input is accepted while a result is pending; there is no skid buffer.
- B=0 or A=0 still runs every digit cycle and gives out_r=0.
- in_approx is sampled only at the accept edge; changes during BUSY are ignored.

Decomposition:
- Package cdm_pkg holds:
  - DIGIT_W = 4.
  - State enum {IDLE, BUSY, DONE}.
  - Function computing the digit count from WIDTH.
- One combinational sub-module, cdm_digit_pp, parameters WIDTH and APPROX_COLS:
  - Inputs: a, d (4 bits), approx.
  - Output: p (WIDTH+4 bits).
  - Implements P(A,d) exactly as defined above.
- Top module holds the FSM, operand registers, shifted accumulator add and handshakes.

Test Plan:
- WIDTH=8, K=6, approx=1, A=3, B=3 -> out_r=7 (exact result 9); out_valid exactly 3 cycles after accept.
- WIDTH=8, K=6, approx=1, A=255, B=255 -> each digit P=3647, out_r=61999. Same operands with approx=0 -> out_r=65025.
- WIDTH=8, K=0, random 1000 operand pairs in approx mode -> out_r equals A*B every time. Independent reference model checks K=6 results bit-exact.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> out_r stable, in_ready=0, extra in_valid ignored. Release -> IDLE, next operands accepted one cycle later.
- Reset asserted in the 2nd BUSY cycle -> next edge shows in_ready=1, out_valid=0, out_r=0. A new transaction (A=2, B=5, approx=0) returns 10 with no stale result.
- WIDTH=16, K=6, A=0xFFFF, B=0x0001, approx=1 -> out_r=0xFFFF, since a single-row digit has no carries; out_valid after 5 cycles.

Source files
------------

// File: rtl/cdm_pkg.sv
// Shared types and constants for the carry-disregard sequential multiplier.
package cdm_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    function automatic int cdm_num_digits(input int width);
        return width / DIGIT_W;
    endfunction

endpackage

// File: rtl/cdm_digit_pp.sv
// One 4-bit-digit partial product A*d, optionally with its low APPROX_COLS
// columns formed as a carry-free OR of the rows.
module cdm_digit_pp
    import cdm_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 6
) (
    input  logic [WIDTH-1:0]         a,
    input  logic [DIGIT_W-1:0]       d,
    input  logic                     approx,
    output logic [WIDTH+DIGIT_W-1:0] p
);

    localparam int PW = WIDTH + DIGIT_W;

    logic [PW-1:0]              low_mask;
    logic [DIGIT_W-1:0][PW-1:0] rows;
    logic [PW-1:0]              exact_sum;
    logic [PW-1:0]              low_or;
    logic [PW-1:0]              high_sum;

    for (genvar j = 0; j < PW; j++) begin : g_mask
        assign low_mask[j] = (j < APPROX_COLS) ? 1'b1 : 1'b0;
    end

    always_comb begin
        exact_sum = '0;
        low_or    = '0;
        high_sum  = '0;
        for (int i = 0; i < DIGIT_W; i++) begin
            rows[i]   = d[i] ? (PW'(a) << i) : '0;
            exact_sum = exact_sum + rows[i];
            low_or    = low_or | (rows[i] & low_mask);
            // Masked rows carry zeros in the low columns, so no carry ever
            // crosses into the OR-ed region and the two parts merge by OR.
            high_sum  = high_sum + (rows[i] & ~low_mask);
        end
        p = approx ? (high_sum | low_or) : exact_sum;
    end

endmodule

// File: rtl/cdm_seq_approx_mul.sv
// Iterative WIDTH x WIDTH multiplier: one B digit per cycle, digit products
// optionally carry-disregarded, exact shifted accumulation.
module cdm_seq_approx_mul
    import cdm_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_approx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_r
);

    localparam int NDIG  = cdm_num_digits(WIDTH);
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PW    = WIDTH + DIGIT_W;
    localparam int RW    = 2 * WIDTH;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               approx_q, approx_d;
    logic [RW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [DIGIT_W-1:0] digit;
    logic [PW-1:0]      pp;
    logic [RW-1:0]      pp_sh;
    logic               last_digit;

    assign digit      = b_q[int'(cnt_q)*DIGIT_W +: DIGIT_W];
    assign pp_sh      = RW'(pp) << (int'(cnt_q) * DIGIT_W);
    assign last_digit = (cnt_q == CNT_W'(NDIG - 1));

    cdm_digit_pp #(
        .WIDTH       (WIDTH),
        .APPROX_COLS (APPROX_COLS)
    ) u_pp (
        .a      (a_q),
        .d      (digit),
        .approx (approx_q),
        .p      (pp)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        approx_d  = approx_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_r     = '0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    approx_d = in_approx;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                // Approximate digit products never exceed exact ones, so
                // the accumulator cannot overflow RW bits.
                acc_d = acc_q + pp_sh;
                if (last_digit) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_r     = acc_q;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            approx_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            approx_q <= approx_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
